// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the Wishbone burst arbiter.
package wb_arb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, cyclic.
module rr_priority_pick #(
    parameter int N = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Walk the requesters starting at the pointer and take the first one.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(off);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_burst_arbiter.sv
// Round-robin Wishbone B4 arbiter: cycle-atomic grants, ack timeout, beat/burst statistics.
module wb_burst_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_WIDTH   = 30,
    parameter int DAT_WIDTH   = 32,
    parameter int SEL_WIDTH   = 4,
    parameter int TIMEOUT     = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_w,
    output logic [DAT_WIDTH-1:0]             m_dat_r,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel,
    input  logic [NUM_MASTERS-1:0]           m_cyc,
    input  logic [NUM_MASTERS-1:0]           m_stb,
    input  logic [NUM_MASTERS-1:0]           m_we,
    input  logic [NUM_MASTERS*3-1:0]         m_cti,
    input  logic [NUM_MASTERS*2-1:0]         m_bte,
    output logic [NUM_MASTERS-1:0]           m_ack,
    output logic [NUM_MASTERS-1:0]           m_err,
    output logic [ADR_WIDTH-1:0]             s_adr,
    output logic [DAT_WIDTH-1:0]             s_dat_w,
    output logic [SEL_WIDTH-1:0]             s_sel,
    output logic                             s_cyc,
    output logic                             s_stb,
    output logic                             s_we,
    output logic [2:0]                       s_cti,
    output logic [1:0]                       s_bte,
    input  logic [DAT_WIDTH-1:0]             s_dat_r,
    input  logic                             s_ack,
    input  logic                             s_err,
    output logic [NUM_MASTERS-1:0]           grant,
    output logic [CNT_WIDTH-1:0]             beat_count,
    output logic [CNT_WIDTH-1:0]             burst_count,
    output logic [CNT_WIDTH-1:0]             timeout_count
);

    localparam int PW = $clog2(NUM_MASTERS);
    localparam int TW = 16;

    state_e               state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] beat_q, burst_q, tcnt_q;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [PW-1:0]        owner;
    logic                 busy, stb_raw, tmo_fire, beat;

    rr_priority_pick #(.N(NUM_MASTERS)) u_pick (
        .req_i (m_cyc),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt)
    );

    // Encode the one-hot grant into an index for the slave-side muxes.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (grant_q[i]) owner = PW'(i);
    end

    assign busy     = |grant_q;
    assign stb_raw  = busy & m_stb[owner];
    // Fires only on the cycle the wait reaches TIMEOUT; a real ack/err that cycle wins.
    assign tmo_fire = stb_raw & ~s_ack & ~s_err & (tmo_q == TW'(TIMEOUT - 1));
    assign beat     = stb_raw & s_ack & ~s_err;

    // Slave side follows the owner combinationally; quiet when nobody is granted.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cyc   = 1'b0;
        s_we    = 1'b0;
        s_cti   = '0;
        s_bte   = '0;
        if (busy) begin
            s_adr   = m_adr[int'(owner)*ADR_WIDTH +: ADR_WIDTH];
            s_dat_w = m_dat_w[int'(owner)*DAT_WIDTH +: DAT_WIDTH];
            s_sel   = m_sel[int'(owner)*SEL_WIDTH +: SEL_WIDTH];
            s_cyc   = m_cyc[owner];
            s_we    = m_we[owner];
            s_cti   = m_cti[int'(owner)*3 +: 3];
            s_bte   = m_bte[int'(owner)*2 +: 2];
        end
    end

    assign s_stb   = stb_raw & ~tmo_fire;
    assign m_ack   = grant_q & {NUM_MASTERS{beat}};
    assign m_err   = grant_q & {NUM_MASTERS{stb_raw & (s_err | tmo_fire)}};
    assign m_dat_r = s_dat_r;

    assign grant         = grant_q;
    assign beat_count    = beat_q;
    assign burst_count   = burst_q;
    assign timeout_count = tcnt_q;

    // Wait counter restarts on every termination and whenever stb is low.
    always_comb begin
        tmo_d = tmo_q + TW'(1);
        if (!stb_raw || s_ack || s_err || tmo_fire) tmo_d = '0;
    end

    // Grant FSM: hold the owner for its whole cycle, then one idle cycle before the next.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    grant_d = pick_gnt;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!m_cyc[owner]) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                    ptr_d   = (owner == PW'(NUM_MASTERS - 1)) ? '0 : owner + PW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer, timeout and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            if (beat)                      beat_q  <= beat_q + CNT_WIDTH'(1);
            if (beat && s_cti == CTI_END)  burst_q <= burst_q + CNT_WIDTH'(1);
            if (tmo_fire)                  tcnt_q  <= tcnt_q + CNT_WIDTH'(1);
        end
    end

endmodule
